alu_sequencer: RTL and testbench

Upstream operand/instruction stage for the 8-bit combinational `alu`. It holds an 8-entry × 8-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it drives `A`/`B`/`OP` into the ALU, captures `Y` and the `C`/`V`/`N`/`Z` flags, and writes the result back to the register file and a flag register. It also provides a combinational debug read port that feeds the seven-segment drivers.

---
 rtl/alu_sequencer.sv | 106 ++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Operand/instruction sequencer for the 8-bit combinational alu: 8x8 register
// file, one instruction in flight, IDLE -> (EXEC) -> WB with writeback at WB exit.
module alu_sequencer (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       INSTR_VALID,
    output logic       INSTR_READY,
    input  logic       INSTR_LI,
    input  logic [2:0] INSTR_OP,
    input  logic [2:0] INSTR_RD,
    input  logic [2:0] INSTR_RS,
    input  logic [2:0] INSTR_RT,
    input  logic [7:0] IMM,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_OP,
    input  logic [7:0] ALU_Y,
    input  logic       ALU_C,
    input  logic       ALU_V,
    input  logic       ALU_N,
    input  logic       ALU_Z,
    output logic [3:0] FLAGS,
    output logic [7:0] RESULT,
    output logic       DONE,
    input  logic [2:0] DBG_SEL,
    output logic [7:0] DBG_DATA
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0] state, next_state;
    logic [7:0] regfile [8];
    logic       ready_q;
    logic       li_q;
    logic [2:0] rd_q;
    logic [7:0] hold_y;
    logic [3:0] hold_flags;
    logic       accept;

    // ready_q is registered so READY only rises one edge after reset release
    assign accept      = INSTR_VALID & ready_q;
    assign INSTR_READY = ready_q;
    assign DONE        = (state == WB);
    assign DBG_DATA    = regfile[DBG_SEL];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = INSTR_LI ? WB : EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            li_q       <= 1'b0;
            rd_q       <= '0;
            hold_y     <= '0;
            hold_flags <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_OP     <= '0;
            FLAGS      <= '0;
            RESULT     <= '0;
            for (int i = 0; i < 8; i++) regfile[i] <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
            case (state)
                IDLE: if (accept) begin
                    rd_q <= INSTR_RD;
                    li_q <= INSTR_LI;
                    if (INSTR_LI) begin
                        hold_y <= IMM;
                    end else begin
                        ALU_A  <= regfile[INSTR_RS];
                        ALU_B  <= regfile[INSTR_RT];
                        ALU_OP <= INSTR_OP;
                    end
                end
                EXEC: begin
                    hold_y     <= ALU_Y;
                    hold_flags <= {ALU_C, ALU_V, ALU_N, ALU_Z};
                end
                WB: begin
                    // LI leaves FLAGS alone; the reserved opcode retires with no side effects
                    if (li_q) begin
                        regfile[rd_q] <= hold_y;
                        RESULT        <= hold_y;
                    end else if (ALU_OP != OP_NOP) begin
                        regfile[rd_q] <= hold_y;
                        RESULT        <= hold_y;
                        FLAGS         <= hold_flags;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural alu attached, directed table, handshake/abort
// sequences and random instructions checked against an array-based model.
module tb_alu_sequencer;
    logic       CLK = 1'b0;
    logic       RESET_L;
    logic       INSTR_VALID, INSTR_READY, INSTR_LI;
    logic [2:0] INSTR_OP, INSTR_RD, INSTR_RS, INSTR_RT;
    logic [7:0] IMM, ALU_A, ALU_B, ALU_Y, RESULT, DBG_DATA;
    logic [2:0] ALU_OP, DBG_SEL;
    logic       ALU_C, ALU_V, ALU_N, ALU_Z, DONE;
    logic [3:0] FLAGS;

    int checks = 0;
    int failures = 0;

    logic [7:0] reg_m [8];
    logic [3:0] flags_m;
    logic [7:0] result_m;

    always #5 CLK = ~CLK;

    // returns {C,V,N,Z,Y}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] s;
        logic [7:0] y;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0; y = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; y = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (y[7] != a[7]); end
            3'd2: begin y = $signed(a) >>> 1; c = a[0]; end
            3'd3: begin y = a >> 1; c = a[0]; end
            3'd4: begin y = a << 1; c = a[7]; end
            3'd5: y = a & b;
            3'd6: y = a | b;
            default: y = '0;
        endcase
        return {c, v, y[7], (y == 8'd0), y};
    endfunction

    assign {ALU_C, ALU_V, ALU_N, ALU_Z, ALU_Y} = alu_fn(ALU_A, ALU_B, ALU_OP);

    alu_sequencer dut (
        .CLK(CLK), .RESET_L(RESET_L),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR_LI(INSTR_LI),
        .INSTR_OP(INSTR_OP), .INSTR_RD(INSTR_RD), .INSTR_RS(INSTR_RS), .INSTR_RT(INSTR_RT),
        .IMM(IMM), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_Y(ALU_Y),
        .ALU_C(ALU_C), .ALU_V(ALU_V), .ALU_N(ALU_N), .ALU_Z(ALU_Z),
        .FLAGS(FLAGS), .RESULT(RESULT), .DONE(DONE), .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) reg_m[i] = '0;
        flags_m = '0;
        result_m = '0;
    endtask

    task automatic check_state(input string name);
        for (int i = 0; i < 8; i++) begin
            DBG_SEL = 3'(i);
            #1;
            chk($sformatf("%s_r%0d", name, i), DBG_DATA, reg_m[i]);
        end
        chk({name, "_result"}, RESULT, result_m);
        chk({name, "_flags"}, FLAGS, flags_m);
    endtask

    // Call at a negedge with nothing in flight; returns at the negedge after retirement.
    task automatic issue(input bit li, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm);
        logic [7:0] ea, eb;
        logic [11:0] r;
        int n;
        ea = reg_m[rs];
        eb = reg_m[rt];
        INSTR_LI = li; INSTR_OP = op; INSTR_RD = rd; INSTR_RS = rs; INSTR_RT = rt; IMM = imm;
        INSTR_VALID = 1'b1;
        n = 0;
        while (!INSTR_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_wait", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        if (n >= 20) begin
            INSTR_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        chk("ready_low_after_accept", INSTR_READY, 1'b0);
        if (li) begin
            chk("li_done_wb", DONE, 1'b1);
            reg_m[rd] = imm;
            result_m = imm;
        end else begin
            chk("exec_alu_a", ALU_A, ea);
            chk("exec_alu_b", ALU_B, eb);
            chk("exec_alu_op", ALU_OP, op);
            chk("exec_done_low", DONE, 1'b0);
            @(negedge CLK);
            chk("wb_done", DONE, 1'b1);
            chk("wb_ready_low", INSTR_READY, 1'b0);
            r = alu_fn(ea, eb, op);
            if (op != 3'b111) begin
                reg_m[rd] = r[7:0];
                result_m = r[7:0];
                flags_m = r[11:8];
            end
        end
        @(negedge CLK);
        chk("done_one_cycle", DONE, 1'b0);
        chk("ready_back", INSTR_READY, 1'b1);
        DBG_SEL = rd;
        #1;
        chk("wb_dbg_rd", DBG_DATA, reg_m[rd]);
        chk("wb_result", RESULT, result_m);
        chk("wb_flags", FLAGS, flags_m);
    endtask

    typedef struct {
        bit         li;
        logic [2:0] op, rd, rs, rt;
        logic [7:0] imm;
        logic [7:0] exp_y;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int k;
        int done_cnt;
        tbl[0] = '{1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 8'h35, 8'h35, 4'b0000};
        tbl[1] = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 8'h0F, 8'h0F, 4'b0000};
        tbl[2] = '{1'b0, 3'd5, 3'd3, 3'd1, 3'd2, 8'h00, 8'h05, 4'b0000};
        tbl[3] = '{1'b0, 3'd5, 3'd4, 3'd2, 3'd0, 8'h00, 8'h00, 4'b0001};
        tbl[4] = '{1'b0, 3'd4, 3'd1, 3'd1, 3'd1, 8'h00, 8'h6A, 4'b0000};

        RESET_L = 1'b0;
        INSTR_VALID = 1'b0; INSTR_LI = 1'b0; INSTR_OP = '0;
        INSTR_RD = '0; INSTR_RS = '0; INSTR_RT = '0; IMM = '0; DBG_SEL = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_ready", INSTR_READY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_alu_a", ALU_A, 8'h00);
        check_state("rst");
        @(negedge CLK);
        RESET_L = 1'b1;
        #1 chk("ready_low_at_release", INSTR_READY, 1'b0);
        @(negedge CLK);
        chk("ready_after_release", INSTR_READY, 1'b1);

        // directed table: LI, LI, AND, AND -> zero, SLL in place
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i].li, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm);
            DBG_SEL = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_reg", i), DBG_DATA, tbl[i].exp_y);
            chk($sformatf("tbl%0d_result", i), RESULT, tbl[i].exp_y);
            chk($sformatf("tbl%0d_flags", i), FLAGS, tbl[i].exp_flags);
        end

        // reserved op with VALID held: next instruction accepted exactly 3 edges later
        INSTR_LI = 1'b0; INSTR_OP = 3'b111; INSTR_RD = 3'd3; INSTR_RS = 3'd1; INSTR_RT = 3'd2;
        INSTR_VALID = 1'b1;
        chk("nop_ready", INSTR_READY, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        INSTR_OP = 3'd6; INSTR_RD = 3'd6;
        done_cnt = 0;
        k = 1;
        while (!INSTR_READY && k < 10) begin
            if (DONE) done_cnt++;
            @(negedge CLK);
            k++;
        end
        chk("nop_to_or_cycles", k, 3);
        chk("nop_done_pulses", done_cnt, 1);
        check_state("after_nop");
        issue(1'b0, 3'd6, 3'd6, 3'd1, 3'd2, 8'h00);
        DBG_SEL = 3'd6;
        #1 chk("or_r6", DBG_DATA, 8'h6F);

        // abort OR R5 = R1 | R2 during EXEC
        INSTR_LI = 1'b0; INSTR_OP = 3'd6; INSTR_RD = 3'd5; INSTR_RS = 3'd1; INSTR_RT = 3'd2;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        chk("abort_exec_op", ALU_OP, 3'd6);
        RESET_L = 1'b0;
        #1;
        chk("abort_done", DONE, 1'b0);
        chk("abort_ready", INSTR_READY, 1'b0);
        chk("abort_alu_a", ALU_A, 8'h00);
        done_cnt = 0;
        repeat (2) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        RESET_L = 1'b1;
        @(negedge CLK);
        if (DONE) done_cnt++;
        chk("abort_ready_idle", INSTR_READY, 1'b1);
        chk("abort_no_done", done_cnt, 0);
        model_reset();
        check_state("abort");

        // random instructions against the model
        for (int i = 0; i < 60; i++) begin
            issue(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        check_state("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
